// File: rtl/cm_sort_iter.sv
// Iterative odd-even transposition sorter: one key bank reused for one phase per clock,
// valid/ready on both sides, stable ordering, source-index permutation and optional early exit.
module cm_sort_iter #(
  parameter  int DATA_CNT   = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int EARLY_EXIT = 1,
  localparam int IDX_WIDTH  = $clog2(DATA_CNT),
  localparam int PH_WIDTH   = $clog2(DATA_CNT + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_vld,
  output logic                           o_rdy,
  input  logic                           i_desc,
  input  logic [DATA_CNT*DATA_WIDTH-1:0] i_data,
  output logic                           o_vld,
  input  logic                           i_rdy,
  output logic [DATA_CNT*DATA_WIDTH-1:0] o_data,
  output logic [DATA_CNT*IDX_WIDTH-1:0]  o_idx,
  output logic [PH_WIDTH-1:0]            o_phases
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_key [DATA_CNT];
  logic [IDX_WIDTH-1:0]  r_idx [DATA_CNT];
  logic [DATA_WIDTH-1:0] w_key [DATA_CNT];
  logic [IDX_WIDTH-1:0]  w_idx [DATA_CNT];
  logic                  r_desc;
  logic                  r_prevClean;
  logic [PH_WIDTH-1:0]   r_phase;
  logic [PH_WIDTH-1:0]   w_phaseInc;
  logic                  w_swapAny;
  logic                  w_accept;
  logic                  w_last;

  if (DATA_CNT < 2) begin : g_badCnt
    $error("cm_sort_iter: DATA_CNT must be >= 2");
  end

  assign o_rdy    = (r_state == IDLE) & ~i_rst;
  assign o_vld    = (r_state == DONE);
  assign o_phases = r_phase;
  assign w_accept = o_rdy & i_vld;

  // One compare-exchange phase; pairs start at lane 0 on even phases, lane 1 on odd ones.
  // Only strictly out-of-order pairs swap, which keeps equal keys in input order.
  always_comb begin
    w_key     = r_key;
    w_idx     = r_idx;
    w_swapAny = 1'b0;
    for (int k = 0; k < DATA_CNT - 1; k++) begin
      if (k[0] == r_phase[0]) begin
        if (r_desc ? (r_key[k] < r_key[k+1]) : (r_key[k] > r_key[k+1])) begin
          w_key[k]   = r_key[k+1];
          w_key[k+1] = r_key[k];
          w_idx[k]   = r_idx[k+1];
          w_idx[k+1] = r_idx[k];
          w_swapAny  = 1'b1;
        end
      end
    end
  end

  assign w_phaseInc = r_phase + PH_WIDTH'(1);
  assign w_last     = (w_phaseInc == PH_WIDTH'(DATA_CNT)) |
                      ((EARLY_EXIT != 0) & r_prevClean & ~w_swapAny);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SORT;
      SORT:    if (w_last)   w_nextState = DONE;
      DONE:    if (i_rdy)    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // r_prevClean remembers whether the previous phase was swap-free; cleared on accept
  // so a single clean phase can never end the sort on its own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DATA_CNT; k++) begin
        r_key[k] <= '0;
        r_idx[k] <= '0;
      end
      r_desc      <= 1'b0;
      r_prevClean <= 1'b0;
      r_phase     <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < DATA_CNT; k++) begin
        r_key[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
        r_idx[k] <= IDX_WIDTH'(k);
      end
      r_desc      <= i_desc;
      r_prevClean <= 1'b0;
      r_phase     <= '0;
    end else if (r_state == SORT) begin
      r_key       <= w_key;
      r_idx       <= w_idx;
      r_phase     <= w_phaseInc;
      r_prevClean <= ~w_swapAny;
    end
  end

  always_comb begin
    o_data = '0;
    o_idx  = '0;
    for (int k = 0; k < DATA_CNT; k++) begin
      o_data[k*DATA_WIDTH +: DATA_WIDTH] = r_key[k];
      o_idx[k*IDX_WIDTH +: IDX_WIDTH]    = r_idx[k];
    end
  end

endmodule

// File: tb/tb_cm_sort_iter.sv
// Directed and random checks of cm_sort_iter across several DATA_CNT / EARLY_EXIT builds.
module tb_cm_sort_iter;

  localparam int DW = 16;

  localparam logic [127:0] VEC_A  = {16'd4, 16'd2, 16'd6, 16'd0, 16'd1, 16'd7, 16'd3, 16'd5};
  localparam logic [127:0] SORT_A = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
  localparam logic [23:0]  IDX_A  = {3'd2, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd3, 3'd4};
  localparam logic [127:0] VEC_B  = {16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [127:0] SORT_B = {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
  localparam logic [23:0]  IDX_B  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [127:0] VEC_R  = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   inK  [17];
  int   expK [17];
  int   expI [17];

  logic         m_vld, m_rdy, m_desc, m_ovld, m_drdy;
  logic [127:0] m_din, m_dout;
  logic [23:0]  m_idx;
  logic [3:0]   m_ph;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cm_sort_iter #(.DATA_CNT(8), .DATA_WIDTH(DW), .EARLY_EXIT(1)) u_main (
    .i_clk(clk), .i_rst(rst), .i_vld(m_vld), .o_rdy(m_rdy), .i_desc(m_desc),
    .i_data(m_din), .o_vld(m_ovld), .i_rdy(m_drdy), .o_data(m_dout),
    .o_idx(m_idx), .o_phases(m_ph)
  );

  // Index 5 is the default build (8 keys, early exit); index 0 is the same size without it.
  for (genvar g = 0; g < 6; g++) begin : g_inst
    localparam int N  = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 2 : (g == 3) ? 3 : (g == 4) ? 17 : 8;
    localparam int EE = (g == 0) ? 0 : 1;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);

    logic            vld, rdy, desc, ovld, drdy;
    logic [N*DW-1:0] din, dout;
    logic [N*IW-1:0] idx;
    logic [PW-1:0]   phases;

    initial begin
      vld  = 1'b0;
      desc = 1'b0;
      drdy = 1'b1;
      din  = '0;
    end

    cm_sort_iter #(.DATA_CNT(N), .DATA_WIDTH(DW), .EARLY_EXIT(EE)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(rdy), .i_desc(desc),
      .i_data(din), .o_vld(ovld), .i_rdy(drdy), .o_data(dout),
      .o_idx(idx), .o_phases(phases)
    );

    // Sorts inK[0..N-1]; expected comes from expK/expI when useExp, else a stable insertion sort.
    task automatic sort_check(input string name, input logic d, input logic useExp, input int expPh);
      int              rk [N];
      int              ri [N];
      int              tk, ti, j, cyc, lat;
      logic [N*DW-1:0] expD;
      logic [N*IW-1:0] expX;
      for (int k = 0; k < N; k++) begin
        rk[k] = inK[k];
        ri[k] = k;
      end
      for (int i = 1; i < N; i++) begin
        j = i;
        while (j > 0 && (d ? (rk[j-1] < rk[j]) : (rk[j-1] > rk[j]))) begin
          tk = rk[j]; rk[j] = rk[j-1]; rk[j-1] = tk;
          ti = ri[j]; ri[j] = ri[j-1]; ri[j-1] = ti;
          j--;
        end
      end
      if (useExp) begin
        for (int k = 0; k < N; k++) begin
          rk[k] = expK[k];
          ri[k] = expI[k];
        end
      end
      expD = '0;
      expX = '0;
      for (int k = 0; k < N; k++) begin
        expD[k*DW +: DW] = DW'(rk[k]);
        expX[k*IW +: IW] = IW'(ri[k]);
      end

      @(negedge clk);
      for (int k = 0; k < N; k++) din[k*DW +: DW] = DW'(inK[k]);
      desc = d;
      drdy = 1'b1;
      vld  = 1'b1;
      cyc  = 0;
      while (rdy !== 1'b1 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (rdy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s n=%0d accept: o_rdy=%b required 1", name, N, rdy);
        vld = 1'b0;
        return;
      end
      @(posedge clk);
      #1 vld = 1'b0;
      lat = 0;
      while (ovld !== 1'b1 && lat < N + 5) begin
        @(posedge clk);
        #1 lat++;
      end
      checks++;
      if (ovld !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s n=%0d timeout: o_vld=%b after %0d cycles, required 1", name, N, ovld, lat);
        return;
      end
      checks++;
      if (dout !== expD) begin
        failures++;
        $display("[TB] FAIL %s n=%0d data: got %h required %h", name, N, dout, expD);
      end
      checks++;
      if (idx !== expX) begin
        failures++;
        $display("[TB] FAIL %s n=%0d idx: got %h required %h", name, N, idx, expX);
      end
      checks++;
      if (lat != int'(phases)) begin
        failures++;
        $display("[TB] FAIL %s n=%0d latency: got %0d cycles required o_phases=%0d", name, N, lat, phases);
      end
      if (expPh >= 0) begin
        checks++;
        if (int'(phases) != expPh) begin
          failures++;
          $display("[TB] FAIL %s n=%0d phases: got %0d required %0d", name, N, phases, expPh);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (ovld !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s n=%0d handoff: o_vld=%b required 0", name, N, ovld);
      end
    endtask

    task automatic run_random(input int count);
      for (int t = 0; t < count; t++) begin
        for (int k = 0; k < N; k++)
          inK[k] = (t % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
        sort_check("random", 1'($urandom_range(0, 1)), 1'b0, (EE != 0) ? -1 : N);
      end
    endtask
  end

  task automatic set_in(input int a0, a1, a2, a3, a4, a5, a6, a7);
    inK = '{a0, a1, a2, a3, a4, a5, a6, a7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic set_exp(input int a0, a1, a2, a3, a4, a5, a6, a7);
    expK = '{a0, a1, a2, a3, a4, a5, a6, a7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic set_idx(input int a0, a1, a2, a3, a4, a5, a6, a7);
    expI = '{a0, a1, a2, a3, a4, a5, a6, a7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic main_wait_vld(output int lat);
    lat = 0;
    while (m_ovld !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (m_ovld !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset rdy: got %b required 0", m_rdy); end
    checks++;
    if (m_ovld !== 1'b0) begin failures++; $display("[TB] FAIL reset vld: got %b required 0", m_ovld); end
    checks++;
    if ({m_dout, m_idx, m_ph} !== '0) begin
      failures++;
      $display("[TB] FAIL reset outputs: data=%h idx=%h phases=%0d required all 0", m_dout, m_idx, m_ph);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_rdy !== 1'b1 || m_ovld !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release: rdy=%b vld=%b required 1/0", m_rdy, m_ovld);
    end
  endtask

  task automatic test_sort_asc();
    set_in(5, 3, 7, 1, 0, 6, 2, 4);
    set_exp(0, 1, 2, 3, 4, 5, 6, 7);
    set_idx(4, 3, 6, 1, 7, 0, 5, 2);
    g_inst[5].sort_check("asc8", 1'b0, 1'b1, -1);
  endtask

  task automatic test_sort_desc();
    set_in(5, 3, 7, 1, 0, 6, 2, 4);
    set_exp(7, 6, 5, 4, 3, 2, 1, 0);
    set_idx(2, 5, 0, 7, 1, 6, 3, 4);
    g_inst[5].sort_check("desc8", 1'b1, 1'b1, -1);
  endtask

  task automatic test_early_exit();
    set_in(0, 1, 2, 3, 4, 5, 6, 7);
    set_exp(0, 1, 2, 3, 4, 5, 6, 7);
    set_idx(0, 1, 2, 3, 4, 5, 6, 7);
    g_inst[5].sort_check("sorted_ee1", 1'b0, 1'b1, 2);
    g_inst[0].sort_check("sorted_ee0", 1'b0, 1'b1, 8);
    set_in(7, 6, 5, 4, 3, 2, 1, 0);
    set_idx(7, 6, 5, 4, 3, 2, 1, 0);
    g_inst[5].sort_check("reversed_ee1", 1'b0, 1'b1, 8);
    g_inst[0].sort_check("reversed_ee0", 1'b0, 1'b1, 8);
  endtask

  task automatic test_stability();
    set_in(9, 9, 1, 9, 0, 0, 0, 0);
    set_exp(1, 9, 9, 9, 0, 0, 0, 0);
    set_idx(2, 0, 1, 3, 0, 0, 0, 0);
    g_inst[1].sort_check("stable_asc", 1'b0, 1'b1, -1);
    set_exp(9, 9, 9, 1, 0, 0, 0, 0);
    set_idx(0, 1, 3, 2, 0, 0, 0, 0);
    g_inst[1].sort_check("stable_desc", 1'b1, 1'b1, -1);
  endtask

  task automatic test_backpressure();
    int           lat;
    logic [127:0] snapD;
    logic [23:0]  snapX;
    @(negedge clk);
    m_din  = VEC_A;
    m_desc = 1'b0;
    m_drdy = 1'b0;
    m_vld  = 1'b1;
    checks++;
    if (m_rdy !== 1'b1) begin failures++; $display("[TB] FAIL bp idle rdy: got %b required 1", m_rdy); end
    @(posedge clk);
    #1;
    m_din  = VEC_B;
    m_desc = 1'b1;
    main_wait_vld(lat);
    checks++;
    if (lat < 0) begin failures++; $display("[TB] FAIL bp first result: o_vld=%b required 1", m_ovld); end
    snapD = m_dout;
    snapX = m_idx;
    checks++;
    if (snapD !== SORT_A || snapX !== IDX_A) begin
      failures++;
      $display("[TB] FAIL bp first data: got %h/%h required %h/%h", snapD, snapX, SORT_A, IDX_A);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_ovld !== 1'b1 || m_dout !== snapD || m_idx !== snapX || m_rdy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp hold cycle %0d: vld=%b rdy=%b data=%h idx=%h required 1/0 %h %h",
                 c, m_ovld, m_rdy, m_dout, m_idx, snapD, snapX);
      end
    end
    @(negedge clk);
    m_drdy = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_ovld !== 1'b0 || m_rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp handshake: vld=%b rdy=%b required 0/1", m_ovld, m_rdy);
    end
    @(posedge clk);
    #1;
    m_vld = 1'b0;
    checks++;
    if (m_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp second accept: rdy=%b required 0", m_rdy); end
    main_wait_vld(lat);
    checks++;
    if (lat < 0 || lat != int'(m_ph)) begin
      failures++;
      $display("[TB] FAIL bp second latency: got %0d required o_phases=%0d", lat, m_ph);
    end
    checks++;
    if (m_dout !== SORT_B || m_idx !== IDX_B) begin
      failures++;
      $display("[TB] FAIL bp second data: got %h/%h required %h/%h", m_dout, m_idx, SORT_B, IDX_B);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_sort();
    int   lat;
    logic sawVld;
    @(negedge clk);
    m_din  = VEC_R;
    m_desc = 1'b0;
    m_drdy = 1'b1;
    m_vld  = 1'b1;
    @(posedge clk);
    #1 m_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (m_rdy !== 1'b0 || m_ovld !== 1'b0 || m_dout !== '0) begin
      failures++;
      $display("[TB] FAIL midreset held: rdy=%b vld=%b data=%h required 0/0/0", m_rdy, m_ovld, m_dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m_rdy !== 1'b1) begin failures++; $display("[TB] FAIL midreset release rdy: got %b required 1", m_rdy); end
    sawVld = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (m_ovld !== 1'b0) sawVld = 1'b1;
    end
    checks++;
    if (sawVld !== 1'b0) begin failures++; $display("[TB] FAIL midreset dropped: o_vld seen=%b required 0", sawVld); end
    @(negedge clk);
    m_din = VEC_A;
    m_vld = 1'b1;
    @(posedge clk);
    #1 m_vld = 1'b0;
    main_wait_vld(lat);
    checks++;
    if (lat < 0 || m_dout !== SORT_A || m_idx !== IDX_A) begin
      failures++;
      $display("[TB] FAIL midreset next sort: lat=%0d data=%h idx=%h required %h %h", lat, m_dout, m_idx, SORT_A, IDX_A);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    g_inst[0].run_random(20);
    g_inst[1].run_random(20);
    g_inst[2].run_random(20);
    g_inst[3].run_random(20);
    g_inst[4].run_random(20);
    g_inst[5].run_random(20);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    m_vld    = 1'b0;
    m_desc   = 1'b0;
    m_drdy   = 1'b1;
    m_din    = '0;
    inK      = '{default: 0};
    expK     = '{default: 0};
    expI     = '{default: 0};
    test_reset();
    test_sort_asc();
    test_sort_desc();
    test_early_exit();
    test_stability();
    test_backpressure();
    test_reset_mid_sort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
